// File: rtl/shared_bus_scheduler_pkg.sv
// Shared types and defaults for the zeus bus scheduler.
// Also holds the one-hot to index helper used by the payload mux.
package zeus_bus_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} sched_state_t;

  localparam int DEF_REQUESTERS = 4;
  localparam int DEF_ADDR_W     = 24;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_TIMEOUT    = 255;
  localparam int DEF_MAX_HOLD   = 16;
  localparam int MAX_REQ        = 32;

  function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++)
      if (oh[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/shared_bus_scheduler_if.sv
// Request side and downstream side of the shared bus scheduler.
// slave = scheduler view, master = requesters plus downstream target.
interface shared_bus_scheduler_if #(
  parameter int REQUESTERS = zeus_bus_pkg::DEF_REQUESTERS,
  parameter int ADDR_W     = zeus_bus_pkg::DEF_ADDR_W,
  parameter int DATA_W     = zeus_bus_pkg::DEF_DATA_W
);
  logic [REQUESTERS-1:0]        req_i;
  logic [REQUESTERS-1:0]        lock_i;
  logic [REQUESTERS-1:0]        we_i;
  logic [REQUESTERS*ADDR_W-1:0] addr_i;
  logic [REQUESTERS*DATA_W-1:0] wdata_i;
  logic [REQUESTERS-1:0]        ack_o;
  logic [REQUESTERS-1:0]        err_o;
  logic [DATA_W-1:0]            rdata_o;
  logic [REQUESTERS-1:0]        owner_o;
  logic                         bus_cyc_o;
  logic                         bus_we_o;
  logic [ADDR_W-1:0]            bus_addr_o;
  logic [DATA_W-1:0]            bus_wdata_o;
  logic [DATA_W-1:0]            bus_rdata_i;
  logic                         bus_ack_i;

  modport slave (
    input  req_i, lock_i, we_i, addr_i, wdata_i, bus_rdata_i, bus_ack_i,
    output ack_o, err_o, rdata_o, owner_o, bus_cyc_o, bus_we_o, bus_addr_o, bus_wdata_o
  );

  modport master (
    output req_i, lock_i, we_i, addr_i, wdata_i, bus_rdata_i, bus_ack_i,
    input  ack_o, err_o, rdata_o, owner_o, bus_cyc_o, bus_we_o, bus_addr_o, bus_wdata_o
  );
endinterface

// File: rtl/shared_bus_scheduler_lowest_set_select.sv
// Isolates the lowest set bit of a vector (highest fixed priority).
module lowest_set_select #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);
  assign out_o = in_i & (-in_i);
endmodule

// File: rtl/shared_bus_scheduler.sv
// Fixed-priority scheduler sharing one downstream bus between REQUESTERS masters,
// with bounded lock hold and an ACCESS timeout.
module shared_bus_scheduler
  import zeus_bus_pkg::*;
#(
  parameter int REQUESTERS = DEF_REQUESTERS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int MAX_HOLD   = DEF_MAX_HOLD
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  shared_bus_scheduler_if.slave bus
);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int SEL_W  = $clog2(REQUESTERS);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  sched_state_t            state_q, state_d;
  logic [REQUESTERS-1:0]   owner_q, owner_d;
  logic [REQUESTERS-1:0]   last_q, last_d;
  logic [REQUESTERS-1:0]   ack_q, ack_d;
  logic [REQUESTERS-1:0]   err_q, err_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic                    lock_q, lock_d;

  logic [REQUESTERS-1:0]   pick;
  logic                    keep;
  logic [SEL_W-1:0]        sel;
  logic [ADDR_W-1:0]       addr_arr  [REQUESTERS];
  logic [DATA_W-1:0]       wdata_arr [REQUESTERS];

  lowest_set_select #(.WIDTH(REQUESTERS)) u_pick (.in_i(bus.req_i), .out_o(pick));

  for (genvar g = 0; g < REQUESTERS; g++) begin : g_unpack
    assign addr_arr[g]  = bus.addr_i[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = bus.wdata_i[g*DATA_W +: DATA_W];
  end

  // last_q remembers the previous owner even though owner_o drops to 0 in IDLE
  assign keep = lock_q && (|(bus.req_i & bus.lock_i & last_q)) && (hold_q < HOLD_MAX);

  always_comb begin
    sel = SEL_W'(onehot_to_idx(MAX_REQ'(owner_q)));
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    ack_d   = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    lock_d  = lock_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req_i) begin
          state_d = ACCESS;
          timer_d = '0;
          if (keep) begin
            owner_d = last_q;
            last_d  = last_q;
            hold_d  = hold_q + 1'b1;
          end else begin
            owner_d = pick;
            last_d  = pick;
            hold_d  = HOLD_W'(1);
            lock_d  = 1'b0;
          end
        end
      end
      ACCESS: begin
        // ack has precedence over a timeout landing in the same cycle
        if (bus.bus_ack_i) begin
          state_d = COMPLETE;
          ack_d   = owner_q;
          if (!bus.we_i[sel]) rdata_d = bus.bus_rdata_i;
        end else if (timer_q == TMR_LAST) begin
          state_d = COMPLETE;
          err_d   = owner_q;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      COMPLETE: begin
        state_d = IDLE;
        owner_d = '0;
        lock_d  = (|(bus.lock_i & owner_q)) && !(|err_q);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      timer_q <= '0;
      hold_q  <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
      lock_q  <= lock_d;
    end
  end

  assign bus.bus_cyc_o   = (state_q == ACCESS);
  assign bus.bus_we_o    = bus.bus_cyc_o & bus.we_i[sel];
  assign bus.bus_addr_o  = bus.bus_cyc_o ? addr_arr[sel]  : '0;
  assign bus.bus_wdata_o = bus.bus_cyc_o ? wdata_arr[sel] : '0;
  assign bus.ack_o       = ack_q;
  assign bus.err_o       = err_q;
  assign bus.rdata_o     = rdata_q;
  assign bus.owner_o     = owner_q;

endmodule
